univ_shift_reg_en: RTL
======================

Name: univ_shift_reg_en

Overview:
Parametrised successor to the single-bit enabled preset flip-flop: a WIDTH-bit universal register with clock enable, an asynchronous reset to a programmable preset value, and mode-selected hold/load/shift/rotate. It is the general-purpose storage and serialising element for the team's datapath assignments. It also includes a saturating shift counter so downstream logic knows when a full word has been serialised.

Parameters:
WIDTH, 8, register width in bits (>= 2)
RST_VAL, {WIDTH{1'b1}}, value loaded by asynchronous reset; default is all ones, the preset behaviour
CNT_W, $clog2(WIDTH+1), width of shift counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
E  input  1  clock enable; 0 = hold regardless of MODE
MODE  input  3  000 hold, 001 parallel load, 010 shift left, 011 shift right, 100 rotate left, 101 rotate right, 110 sync clear, 111 hold
D  input  WIDTH  parallel load data
SI  input  1  serial input for shifts
Q  output  WIDTH  register contents
SO  output  1  serial output: Q[WIDTH-1] in left modes, Q[0] in right modes (registered mode select)
shift_cnt  output  CNT_W  number of shifts/rotates since last load, clear or reset; saturates at WIDTH
word_done  output  1  high while shift_cnt == WIDTH

Behaviour:
- rst=1 (async, no clock needed): Q=RST_VAL, shift_cnt=0, word_done=0, SO direction=left, so SO=RST_VAL[WIDTH-1]. Outputs stay forced while rst is high. rst deassertion takes effect at the next edge.
- All updates occur on posedge clk only when rst=0 and E=1. With E=0, Q, shift_cnt and SO direction hold.
- load: Q<=D; shift_cnt<=0.
- shift left: Q<={Q[WIDTH-2:0],SI}. Shift right: Q<={SI,Q[WIDTH-1:1]}.
- rotate left: Q<={Q[WIDTH-2:0],Q[WIDTH-1]}. Rotate right: Q<={Q[0],Q[WIDTH-1:1]}. SI is ignored when rotating.
- Shift and rotate increment shift_cnt by 1, saturating at WIDTH (no wrap).
- sync clear: Q<=0; shift_cnt<=0 (distinct from rst: this is synchronous and gated by E).
- hold codes (000, 111): no change, including the counter.
- SO direction register: set left by 010/100 and right by 011/101; other modes leave it unchanged.
- Latency: Q, SO and shift_cnt are valid one clk after the qualifying edge. word_done is combinational from shift_cnt.
- Simultaneous rst and clock edge: rst wins.
- rst asserted mid-serialisation: discards progress; counter restarts at 0.
- WIDTH boundary: after WIDTH rotates in one direction, Q equals its pre-rotation value and word_done=1.

Optional Feature:
Macro PARITY_OUT_EN.
- Defined: adds output port parity (1 bit) = XOR-reduce of Q, registered so it updates in the same cycle as Q. Reset value = ^RST_VAL.
- Undefined: port absent; no parity logic.

Test Plan:
- Reset: WIDTH=8, pulse rst=1 for 3 ns mid-cycle -> Q=8'hFF immediately, shift_cnt=0, word_done=0. Hold rst across edges -> Q unchanged.
- Load/enable: E=1, MODE=001, D=8'hA5 -> Q=8'hA5 next edge. E=0, MODE=010 for 5 edges -> Q stays 8'hA5, shift_cnt=0.
- Shift/serial: load 8'h81, MODE=010, SI=0, 8 edges -> SO sequence 1,0,0,0,0,0,0,1 (sampled before each edge). Then Q=8'h00, shift_cnt=8, word_done=1; a 9th shift keeps shift_cnt=8.
- Rotate: load 8'h96, MODE=101 for 8 edges -> Q returns to 8'h96, word_done=1. MODE=110 -> Q=0, shift_cnt=0.
- Mid-operation reset: during shift_cnt=3, assert rst between edges -> Q=8'hFF and shift_cnt=0 asynchronously. Resume shifting -> counting restarts from 1.
- Random: 200 cycles of random E/MODE/D/SI against a bench reference model checked 1 ns after each posedge. Repeat with PARITY_OUT_EN defined -> parity==^Q always.

Source files
------------

// File: rtl/univ_shift_reg_en.sv
`default_nettype none
//============================================================================
// Module   : univ_shift_reg_en
// Purpose  : WIDTH-bit universal register with clock enable and asynchronous
//            preset. MODE selects hold / parallel load / shift L/R /
//            rotate L/R / synchronous clear. A saturating counter tracks
//            shifts since the last load/clear/reset, so downstream logic
//            knows when a whole word has been serialised.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
// Parameters
//   WIDTH     register width (>= 2)
//   RST_VAL   value forced onto Q while rst is high
//   CNT_W     width of shift_cnt
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   E          in   clock enable (0 = hold everything)
//   MODE[2:0]  in   000 hold, 001 load, 010 shl, 011 shr,
//                   100 rol, 101 ror, 110 sync clear, 111 hold
//   D          in   parallel load data
//   SI         in   serial input for shifts
//   Q          out  register contents
//   SO         out  serial output, Q MSB (left) or LSB (right)
//   shift_cnt  out  shifts since load/clear/reset, saturating at WIDTH
//   word_done  out  high while shift_cnt == WIDTH
//   parity     out  XOR of Q (only with PARITY_OUT_EN)
// Build option
//   PARITY_OUT_EN : when defined, adds the registered parity output
//============================================================================
module univ_shift_reg_en #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}},
    parameter int               CNT_W   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             E,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SI,
    output logic [WIDTH-1:0] Q,
    output logic             SO,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             word_done
`ifdef PARITY_OUT_EN
    ,
    output logic             parity
`endif
);

    localparam logic [2:0] C_HOLD0 = 3'b000;
    localparam logic [2:0] C_LOAD  = 3'b001;
    localparam logic [2:0] C_SHL   = 3'b010;
    localparam logic [2:0] C_SHR   = 3'b011;
    localparam logic [2:0] C_ROL   = 3'b100;
    localparam logic [2:0] C_ROR   = 3'b101;
    localparam logic [2:0] C_CLR   = 3'b110;
    localparam logic [2:0] C_HOLD7 = 3'b111;

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(WIDTH);

    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir_left;   // SO direction: 1 = MSB side, 0 = LSB side

    logic [WIDTH-1:0] w_q_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_dir_nxt;

    // Saturating increment shared by all shift/rotate modes
    assign w_cnt_inc = (r_cnt == C_CNT_MAX) ? r_cnt : (r_cnt + CNT_W'(1));

    always_comb begin
        w_q_nxt   = r_q;
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir_left;
        case (MODE)
            C_LOAD: begin
                w_q_nxt   = D;
                w_cnt_nxt = '0;
            end
            C_SHL: begin
                w_q_nxt   = {r_q[WIDTH-2:0], SI};
                w_cnt_nxt = w_cnt_inc;
                w_dir_nxt = 1'b1;
            end
            C_SHR: begin
                w_q_nxt   = {SI, r_q[WIDTH-1:1]};
                w_cnt_nxt = w_cnt_inc;
                w_dir_nxt = 1'b0;
            end
            C_ROL: begin
                w_q_nxt   = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                w_cnt_nxt = w_cnt_inc;
                w_dir_nxt = 1'b1;
            end
            C_ROR: begin
                w_q_nxt   = {r_q[0], r_q[WIDTH-1:1]};
                w_cnt_nxt = w_cnt_inc;
                w_dir_nxt = 1'b0;
            end
            C_CLR: begin
                w_q_nxt   = '0;
                w_cnt_nxt = '0;
            end
            C_HOLD0, C_HOLD7: begin
                w_q_nxt   = r_q;
            end
            default: begin
                w_q_nxt   = r_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q        <= RST_VAL;
            r_cnt      <= '0;
            r_dir_left <= 1'b1;
        end else if (E) begin
            r_q        <= w_q_nxt;
            r_cnt      <= w_cnt_nxt;
            r_dir_left <= w_dir_nxt;
        end
    end

`ifdef PARITY_OUT_EN
    logic r_parity;

    // Computed from the next-state value so parity changes on the same edge as Q
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity <= ^RST_VAL;
        end else if (E) begin
            r_parity <= ^w_q_nxt;
        end
    end

    assign parity = r_parity;
`endif

    assign Q         = r_q;
    assign SO        = r_dir_left ? r_q[WIDTH-1] : r_q[0];
    assign shift_cnt = r_cnt;
    assign word_done = (r_cnt == C_CNT_MAX);

endmodule
`default_nettype wire
